cla_addsub_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor that generalises the team's 16-bit combinational CLA add/sub unit to arbitrary width and pipeline depth, with valid/ready flow control. Each operation is split into equal carry-lookahead slices, one slice per pipeline stage, with the inter-slice carry registered between stages. Signed and unsigned overflow, carry-out and zero flags are produced per result. It sits between the operand-issue logic and the writeback path of the datapath.

---
 rtl/cla_addsub_pipe_if.sv | 28 ++
 rtl/cla_addsub_pipe.sv | 161 ++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
// The master side issues operands and accepts results; the slave side is the adder.
interface cla_addsub_pipe_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             subtract;
    logic             sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovflow;
    logic             carry_out;
    logic             zero;

    modport master (
        output in_valid, a, b, subtract, sign, out_ready,
        input  in_ready, out_valid, result, ovflow, carry_out, zero
    );

    modport slave (
        input  in_valid, a, b, subtract, sign, out_ready,
        output in_ready, out_valid, result, ovflow, carry_out, zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one SW-bit lookahead slice per stage,
// inter-slice carry registered, flags produced alongside the final slice.
module cla_addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    cla_addsub_pipe_if.slave bus
);
    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned NG   = SW / GROUP;
    localparam int unsigned LAST = STAGES - 1;

    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] bp_q  [STAGES];
    logic [WIDTH-1:0] bp_d  [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             sub_q [STAGES];
    logic             sub_d [STAGES];
    logic             sgn_q [STAGES];
    logic             sgn_d [STAGES];
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             advance;

    logic             src_v, src_c, src_sub, src_sgn;
    logic [WIDTH-1:0] src_a, src_bp, src_s;
    logic [SW:0]      sa;

    // Two-level lookahead: group G/P from bit g/p, group carries and in-group
    // bit carries both formed as flat sum-of-products, so nothing ripples.
    function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          cin);
        logic [SW-1:0] g, p, c;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        logic          t;
        g = x & y;
        p = x ^ y;
        for (int unsigned j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int unsigned i = 0; i < GROUP; i++) begin
                t = g[j*GROUP+i];
                for (int unsigned m = i + 1; m < GROUP; m++) t &= p[j*GROUP+m];
                gg[j] |= t;
                gp[j] &= p[j*GROUP+i];
            end
        end
        for (int unsigned j = 0; j <= NG; j++) begin
            gc[j] = cin;
            for (int unsigned m = 0; m < j; m++) gc[j] &= gp[m];
            for (int unsigned i = 0; i < j; i++) begin
                t = gg[i];
                for (int unsigned m = i + 1; m < j; m++) t &= gp[m];
                gc[j] |= t;
            end
        end
        for (int unsigned j = 0; j < NG; j++) begin
            for (int unsigned k = 0; k < GROUP; k++) begin
                c[j*GROUP+k] = gc[j];
                for (int unsigned m = 0; m < k; m++) c[j*GROUP+k] &= p[j*GROUP+m];
                for (int unsigned i = 0; i < k; i++) begin
                    t = g[j*GROUP+i];
                    for (int unsigned m = i + 1; m < k; m++) t &= p[j*GROUP+m];
                    c[j*GROUP+k] |= t;
                end
            end
        end
        return {gc[NG], p ^ c};
    endfunction

    always_comb begin
        advance = ~v_q[LAST] | bus.out_ready;
        ovf_d   = 1'b0;
        zero_d  = 1'b0;
        src_v   = 1'b0;
        src_c   = 1'b0;
        src_sub = 1'b0;
        src_sgn = 1'b0;
        src_a   = '0;
        src_bp  = '0;
        src_s   = '0;
        sa      = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            // Stage 0 takes the ports (B inverted for subtract); later stages
            // take the previous stage register, whose full operands ride along.
            src_v   = (k == 0) ? bus.in_valid : v_q[(k == 0) ? 0 : k - 1];
            src_a   = (k == 0) ? bus.a : a_q[(k == 0) ? 0 : k - 1];
            src_bp  = (k == 0) ? (bus.subtract ? ~bus.b : bus.b) : bp_q[(k == 0) ? 0 : k - 1];
            src_s   = (k == 0) ? '0 : s_q[(k == 0) ? 0 : k - 1];
            src_c   = (k == 0) ? bus.subtract : c_q[(k == 0) ? 0 : k - 1];
            src_sub = (k == 0) ? bus.subtract : sub_q[(k == 0) ? 0 : k - 1];
            src_sgn = (k == 0) ? bus.sign : sgn_q[(k == 0) ? 0 : k - 1];

            sa = slice_add(src_a[k*SW +: SW], src_bp[k*SW +: SW], src_c);

            v_d[k]   = src_v;
            a_d[k]   = src_a;
            bp_d[k]  = src_bp;
            s_d[k]   = src_s;
            s_d[k][k*SW +: SW] = sa[SW-1:0];
            c_d[k]   = sa[SW];
            sub_d[k] = src_sub;
            sgn_d[k] = src_sgn;

            if (k == LAST) begin
                if (src_sgn)
                    ovf_d = (src_a[WIDTH-1] == src_bp[WIDTH-1]) &&
                            (s_d[k][WIDTH-1] != src_a[WIDTH-1]);
                else
                    ovf_d = src_sub ? ~sa[SW] : sa[SW];
                zero_d = (s_d[k] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                sgn_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_d[k];
                a_q[k]   <= a_d[k];
                bp_q[k]  <= bp_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                sub_q[k] <= sub_d[k];
                sgn_q[k] <= sgn_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.result    = s_q[LAST];
    assign bus.carry_out = c_q[LAST];
    assign bus.ovflow    = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: 16-bit/2-stage and 32-bit/4-stage instances checked
// against an arithmetic reference model through per-instance scoreboards.
module tb_cla_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla_addsub_pipe_if #(.WIDTH(16)) i16 ();
    cla_addsub_pipe_if #(.WIDTH(32)) i32 ();

    cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) d16 (.clk(clk), .rst_n(rst_n), .bus(i16));
    cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(4)) d32 (.clk(clk), .rst_n(rst_n), .bus(i32));

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        co;
        logic        zr;
        int unsigned acc;
        int unsigned stl;
    } exp_t;

    typedef struct packed {
        logic        sub;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        o;
    } vec_t;

    vec_t tbl [11] = '{
        '{1'b0, 1'b0, 16'h0123, 16'h0345, 16'h0468, 1'b0},
        '{1'b0, 1'b0, 16'hF123, 16'h1345, 16'h0468, 1'b1},
        '{1'b1, 1'b0, 16'hF123, 16'h1345, 16'hDDDE, 1'b0},
        '{1'b1, 1'b0, 16'h1345, 16'hF123, 16'h2222, 1'b1},
        '{1'b0, 1'b1, 16'h7123, 16'h7345, 16'hE468, 1'b1},
        '{1'b0, 1'b1, 16'hF123, 16'hF345, 16'hE468, 1'b0},
        '{1'b0, 1'b1, 16'hA123, 16'hA345, 16'h4468, 1'b1},
        '{1'b1, 1'b1, 16'h2123, 16'hF345, 16'h2DDE, 1'b0},
        '{1'b1, 1'b1, 16'h7123, 16'hA345, 16'hCDDE, 1'b1},
        '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0},
        '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1}
    };

    exp_t        q16[$];
    exp_t        q32[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    int unsigned stl16 = 0;
    int unsigned stl32 = 0;
    logic        dir_on = 1'b0;
    logic [15:0] dir_res = '0;
    logic        dir_ovf = 1'b0;
    logic        rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_model(input int unsigned w, input logic [31:0] a,
                                       input logic [31:0] b, input logic sub, input logic sgn);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned ua   = 64'(a) & mask;
        longint unsigned ub   = 64'(b) & mask;
        longint unsigned raw;
        longint          sa, sb, tv;
        exp_t            e;
        e   = '0;
        raw = sub ? ua + ((~ub) & mask) + 64'd1 : ua + ub;
        e.res = 32'(raw & mask);
        e.co  = raw[w];
        e.zr  = ((raw & mask) == 64'd0);
        if (sgn) begin
            sa = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
            sb = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
            tv = sub ? sa - sb : sa + sb;
            e.ovf = (tv > longint'((64'd1 << (w - 1)) - 64'd1)) || (tv < -longint'(64'd1 << (w - 1)));
        end else begin
            e.ovf = sub ? (ua < ub) : ((ua + ub) > mask);
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd(input int unsigned w);
        logic [31:0] m = (w == 32) ? '1 : (32'd1 << w) - 32'd1;
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return m;
            2:       return 32'd1 << (w - 1);
            3:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    always begin : mon16
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            if (i16.out_valid && i16.out_ready) begin
                if (q16.size() == 0) begin
                    check("w16 unexpected out_valid", 64'(i16.out_valid), 64'd0);
                end else begin
                    e = q16.pop_front();
                    check("w16 result", 64'(i16.result), 64'(e.res[15:0]));
                    check("w16 ovflow", 64'(i16.ovflow), 64'(e.ovf));
                    check("w16 carry_out", 64'(i16.carry_out), 64'(e.co));
                    check("w16 zero", 64'(i16.zero), 64'(e.zr));
                    if (e.stl == stl16) check("w16 latency", 64'(cyc - e.acc), 64'd2);
                end
            end
            if (i16.out_valid && !i16.out_ready) stl16++;
            if (i16.in_valid && i16.in_ready) begin
                e = ref_model(16, 32'(i16.a), 32'(i16.b), i16.subtract, i16.sign);
                if (dir_on) begin
                    e.res = 32'(dir_res);
                    e.ovf = dir_ovf;
                end
                e.acc = cyc;
                e.stl = stl16;
                q16.push_back(e);
            end
        end
    end

    always begin : mon32
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            if (i32.out_valid && i32.out_ready) begin
                if (q32.size() == 0) begin
                    check("w32 unexpected out_valid", 64'(i32.out_valid), 64'd0);
                end else begin
                    e = q32.pop_front();
                    check("w32 result", 64'(i32.result), 64'(e.res));
                    check("w32 ovflow", 64'(i32.ovflow), 64'(e.ovf));
                    check("w32 carry_out", 64'(i32.carry_out), 64'(e.co));
                    check("w32 zero", 64'(i32.zero), 64'(e.zr));
                    if (e.stl == stl32) check("w32 latency", 64'(cyc - e.acc), 64'd4);
                end
            end
            if (i32.out_valid && !i32.out_ready) stl32++;
            if (i32.in_valid && i32.in_ready) begin
                e = ref_model(32, i32.a, i32.b, i32.subtract, i32.sign);
                e.acc = cyc;
                e.stl = stl32;
                q32.push_back(e);
            end
        end
    end

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic sgn);
        int unsigned n = 0;
        i16.a = a; i16.b = b; i16.subtract = sub; i16.sign = sgn; i16.in_valid = 1'b1;
        #1;
        while (!i16.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("w16 in_ready timeout", 64'(i16.in_ready), 64'd1);
        @(negedge clk);
        i16.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic sgn);
        int unsigned n = 0;
        i32.a = a; i32.b = b; i32.subtract = sub; i32.sign = sgn; i32.in_valid = 1'b1;
        #1;
        while (!i32.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("w32 in_ready timeout", 64'(i32.in_ready), 64'd1);
        @(negedge clk);
        i32.in_valid = 1'b0;
    endtask

    task automatic drain(input int unsigned max);
        for (int unsigned i = 0; i < max && (q16.size() != 0 || q32.size() != 0); i++) @(negedge clk);
        check("w16 beats outstanding", 64'(q16.size()), 64'd0);
        check("w32 beats outstanding", 64'(q32.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " w16 out_valid"}, 64'(i16.out_valid), 64'd0);
        check({tag, " w16 result"}, 64'(i16.result), 64'd0);
        check({tag, " w16 ovflow"}, 64'(i16.ovflow), 64'd0);
        check({tag, " w16 carry_out"}, 64'(i16.carry_out), 64'd0);
        check({tag, " w16 zero"}, 64'(i16.zero), 64'd0);
        check({tag, " w16 in_ready"}, 64'(i16.in_ready), 64'd1);
        check({tag, " w32 out_valid"}, 64'(i32.out_valid), 64'd0);
        check({tag, " w32 result"}, 64'(i32.result), 64'd0);
        check({tag, " w32 in_ready"}, 64'(i32.in_ready), 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no end of run, required $finish");
        $fatal(1);
    end

    initial begin : main
        rst_n = 1'b0;
        i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.subtract = 1'b0; i16.sign = 1'b0; i16.out_ready = 1'b1;
        i32.in_valid = 1'b0; i32.a = '0; i32.b = '0; i32.subtract = 1'b0; i32.sign = 1'b0; i32.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed vectors, back to back at full throughput.
        dir_on = 1'b1;
        for (int i = 0; i < 11; i++) begin
            dir_res = tbl[i].r;
            dir_ovf = tbl[i].o;
            send16(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sgn);
        end
        dir_on = 1'b0;
        drain(50);

        // Backpressure: 3 stalled cycles right after the first result.
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                int unsigned n = 0;
                logic [15:0] r;
                logic o, c, z;
                while (!i16.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp first result present", 64'(i16.out_valid), 64'd1);
                i16.out_ready = 1'b0;
                r = i16.result; o = i16.ovflow; c = i16.carry_out; z = i16.zero;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("bp in_ready low", 64'(i16.in_ready), 64'd0);
                    @(negedge clk);
                    check("bp out_valid held", 64'(i16.out_valid), 64'd1);
                    check("bp result held", 64'(i16.result), 64'(r));
                    check("bp ovflow held", 64'(i16.ovflow), 64'(o));
                    check("bp carry_out held", 64'(i16.carry_out), 64'(c));
                    check("bp zero held", 64'(i16.zero), 64'(z));
                end
                i16.out_ready = 1'b1;
            end
        join
        drain(50);

        // Random traffic on both instances with random downstream stalls.
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 1000; i++) begin
                            if ($urandom_range(0, 3) == 0) @(negedge clk);
                            send32(rnd(32), rnd(32), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        end
                    end
                    begin
                        for (int i = 0; i < 300; i++) begin
                            if ($urandom_range(0, 3) == 0) @(negedge clk);
                            send16(16'(rnd(16)), 16'(rnd(16)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        end
                    end
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    i16.out_ready = ($urandom_range(0, 3) != 0);
                    i32.out_ready = ($urandom_range(0, 3) != 0);
                end
                i16.out_ready = 1'b1;
                i32.out_ready = 1'b1;
            end
        join
        drain(100);

        // Reset with beats in flight on both instances.
        fork
            begin
                send16(16'h1234, 16'h1111, 1'b0, 1'b0);
                send16(16'h0F0F, 16'h0101, 1'b0, 1'b0);
            end
            begin
                send32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
                send32(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
            end
        join
        #3;
        check("pre-reset w16 out_valid", 64'(i16.out_valid), 64'd1);
        rst_n = 1'b0;
        q16.delete();
        q32.delete();
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post-reset w16 out_valid", 64'(i16.out_valid), 64'd0);
            check("post-reset w32 out_valid", 64'(i32.out_valid), 64'd0);
        end
        fork
            send16(16'h0001, 16'h0001, 1'b0, 1'b0);
            send32(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        join
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
